// File: rtl/seq_rotate_lr_pkg.sv
// Shared encodings for the sequential left/right rotator: FSM states and direction codes.
package seq_rotate_lr_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/seq_rotate_lr_rot_step.sv
// One-position rotate in either direction; purely combinational, one mux per bit.
module rot_step
  import seq_rotate_lr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  output logic [WIDTH-1:0] dout
);

  // Bit i takes its upper neighbour when rotating right, its lower neighbour when rotating left.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign dout[i] = (dir == DIR_RIGHT) ? din[(i + 1) % WIDTH] : din[(i + WIDTH - 1) % WIDTH];
  end

endmodule

// File: rtl/seq_rotate_lr.sv
// Multi-cycle rotator: one bit position per clock, start/done handshake, r holds the result.
module seq_rotate_lr
  import seq_rotate_lr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [AW-1:0]    amt,
  input  logic             rr,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] r
);

  state_e           state, state_nxt;
  logic [AW-1:0]    count;
  logic             dir;
  logic [WIDTH-1:0] r_step;
  logic             accept;

  rot_step #(.WIDTH(WIDTH)) u_step (
    .din  (r),
    .dir  (dir),
    .dout (r_step)
  );

  assign ready  = (state == S_IDLE) || (state == S_DONE);
  assign done   = (state == S_DONE);
  assign accept = start && ready;

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = accept ? ((amt != '0) ? S_SHIFT : S_DONE) : S_IDLE;
      S_SHIFT: state_nxt = (count == AW'(1)) ? S_DONE : S_SHIFT;
      // DONE may accept back-to-back; otherwise it lasts exactly one cycle.
      S_DONE:  state_nxt = accept ? ((amt != '0) ? S_SHIFT : S_DONE) : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      r     <= '0;
      count <= '0;
      dir   <= DIR_LEFT;
    end else begin
      state <= state_nxt;
      if (accept) begin
        r     <= a;
        count <= amt;
        dir   <= rr;
      end else if (state == S_SHIFT) begin
        // SHIFT is only entered with count >= 1, so this never wraps.
        r     <= r_step;
        count <= count - AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_rotate_lr.sv
// Self-checking bench for seq_rotate_lr: directed cases, exhaustive sweep, random ops.
module tb_seq_rotate_lr;

  localparam int WIDTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [AW-1:0]    amt;
  logic             rr;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] r;

  int checks = 0;
  int errors = 0;

  seq_rotate_lr #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .amt   (amt),
    .rr    (rr),
    .ready (ready),
    .done  (done),
    .r     (r)
  );

  always #5 clk = ~clk;

  // Reference: rotating is taking a window of the operand concatenated with itself.
  function automatic logic [WIDTH-1:0] rot_model(input logic [WIDTH-1:0] v,
                                                 input int n, input logic right);
    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] sh;
    dbl = {v, v};
    if (right) begin
      sh = dbl >> n;
      return sh[WIDTH-1:0];
    end else begin
      sh = dbl << n;
      return sh[2*WIDTH-1:WIDTH];
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in a cycle where ready should be high.
  task automatic issue(input logic [WIDTH-1:0] av, input logic [AW-1:0] nv, input logic rv);
    check("ready_at_issue", 32'(ready), 32'd1);
    a     = av;
    amt   = nv;
    rr    = rv;
    start = 1'b1;
  endtask

  // Waits through the operation; returns at the negedge of the done cycle when b2b=1.
  task automatic finish_op(input string tag, input logic [WIDTH-1:0] exp_r, input int n,
                           input bit hold, input bit b2b);
    int lat;
    bit rdy_bad;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    // Scramble operands after acceptance; they must not matter any more.
    a   = WIDTH'($urandom);
    amt = AW'($urandom);
    rr  = 1'($urandom);
    lat = 0;
    rdy_bad = 1'b0;
    while (!done && lat < 2 * WIDTH + 4) begin
      if (ready !== 1'b0) rdy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(n));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_result"}, 32'(r), 32'(exp_r));
    check({tag, "_ready_low_in_shift"}, 32'(rdy_bad), 32'd0);
    if (!b2b) begin
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_r_held"}, 32'(r), 32'(exp_r));
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [AW-1:0]    rn;
    logic             rd;
    bit               saw_done;

    reset = 1'b1;
    start = 1'b0;
    a = '0; amt = '0; rr = 1'b0;
    @(negedge clk);
    start = 1'b1;  // reset must win over start
    @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_r", 32'(r), 32'd0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    issue(8'hB1, 3'd3, 1'b0); finish_op("t1_left", 8'h8D, 3, 1'b0, 1'b0);
    issue(8'hB1, 3'd3, 1'b1); finish_op("t2_right", 8'h36, 3, 1'b0, 1'b0);
    issue(8'h5A, 3'd0, 1'b0); finish_op("t3_zero_l", 8'h5A, 0, 1'b0, 1'b0);
    issue(8'h5A, 3'd0, 1'b1); finish_op("t3_zero_r", 8'h5A, 0, 1'b0, 1'b0);
    issue(8'h01, 3'd7, 1'b0); finish_op("t4_hold", 8'h80, 7, 1'b1, 1'b0);

    // Back-to-back round trip
    issue(8'hB1, 3'd3, 1'b0); finish_op("t5_first", 8'h8D, 3, 1'b0, 1'b1);
    issue(8'h8D, 3'd3, 1'b1); finish_op("t5_second", 8'hB1, 3, 1'b0, 1'b0);

    // Reset mid-SHIFT
    issue(8'hC3, 3'd7, 1'b1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_r", 32'(r), 32'd0);
    check("t6_ready", 32'(ready), 32'd1);
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    check("t6_no_done", 32'(saw_done), 32'd0);

    // Exhaustive sweep
    for (int v = 0; v < 256; v++)
      for (int n = 0; n < WIDTH; n++)
        for (int d = 0; d < 2; d++) begin
          issue(WIDTH'(v), AW'(n), 1'(d));
          finish_op("sweep", rot_model(WIDTH'(v), n, 1'(d)), n, 1'b0, 1'b1);
        end
    start = 1'b0;
    @(negedge clk);

    // Random ops, random start holding
    for (int i = 0; i < 200; i++) begin
      ra = WIDTH'($urandom);
      rn = AW'($urandom_range(0, WIDTH - 1));
      rd = 1'($urandom);
      issue(ra, rn, rd);
      finish_op("rand", rot_model(ra, int'(rn), rd), int'(rn), 1'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
